div_unit: RTL

- Iterative radix-2 restoring divider for the EX stage. Handles signed and unsigned DIV/DIVU.
- Consumes the operand values selected by the EX-stage operand muxes (forwarded or register-file values).
- Produces the quotient and remainder that the writeback and HI/LO muxes select for the HI/LO write.
- Holds the pipeline via busy while it iterates.

---
 rtl/cpu_defs_pkg.sv | 19 +
 rtl/div_step.sv | 31 +++
 rtl/div_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: divider FSM state encoding, datapath width and
// the DIV/DIVU opcode/funct encodings used by the decoder to drive start and
// signed_div on div_unit.
package cpu_defs;

  localparam int unsigned DIV_WIDTH = 32;

  // SPECIAL-class R-type opcode and the divide funct codes
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring-division iteration, kept as its own combinational
// unit so the trial subtract can be timed in isolation.
// Ports:
//   i_rem      partial remainder before the shift
//   i_dvd_msb  dividend bit shifted into the remainder
//   i_dvsr     divisor magnitude
//   o_rem_c    partial remainder after this iteration
//   o_q_bit_c  quotient bit produced by this iteration
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem_c,
  output logic             o_q_bit_c
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  // The shifted remainder needs WIDTH+1 bits; when it is >= the divisor the
  // difference is below the divisor, so a WIDTH-bit subtract is exact.
  always_comb begin
    w_shift   = {i_rem, i_dvd_msb};
    w_diff    = w_shift[WIDTH-1:0] - i_dvsr;
    o_q_bit_c = (w_shift >= {1'b0, i_dvsr});
    o_rem_c   = o_q_bit_c ? w_diff : w_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Optional feature macro: DIV_ZERO_CHECK_EN (early exit on zero divisor and
// the div_by_zero flag port).
// Ports:
//   clk, rst     clock and synchronous active-low reset
//   start        divide request, accepted only in IDLE without annul
//   signed_div   1 = DIV, 0 = DIVU; captured with start
//   annul        abort the operation in flight
//   a, b         dividend / divisor; captured with start
//   busy         high while iterating (pipeline stall source)
//   done         one-cycle pulse, results valid with it
//   quotient     LO value
//   remainder    HI value
//   div_by_zero  zero-divisor flag with done (DIV_ZERO_CHECK_EN only)
module div_unit
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
`ifdef DIV_ZERO_CHECK_EN
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
`else
  output logic [WIDTH-1:0] remainder
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  div_state_t       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] r_dvsr;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
`ifdef DIV_ZERO_CHECK_EN
  logic             r_dbz;
`endif

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_next_rem;
  logic             w_q_bit;

  // Operand signs and magnitudes; -2^(WIDTH-1) keeps its bit pattern, which is
  // the correct unsigned magnitude.
  always_comb begin
    w_sa    = signed_div & a[WIDTH-1];
    w_sb    = signed_div & b[WIDTH-1];
    w_a_mag = w_sa ? WIDTH'(-a) : a;
    w_b_mag = w_sb ? WIDTH'(-b) : b;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_dvsr    (r_dvsr),
    .o_rem_c   (w_next_rem),
    .o_q_bit_c (w_q_bit)
  );

  // Control FSM and datapath; outputs are written only when leaving DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dvsr    <= '0;
      r_cnt     <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_CHECK_EN
      r_dbz       <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      div_by_zero <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (start && !annul) begin
            r_sign_q <= w_sa ^ w_sb;
            r_sign_r <= w_sa;
            r_dvd    <= w_a_mag;
            r_dvsr   <= w_b_mag;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_state  <= BUSY;
            busy     <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
            r_dbz <= 1'b0;
            // Zero divisor: preload the raw result and skip the iterations
            if (b == '0) begin
              r_dvd    <= '1;
              r_rem    <= a;
              r_sign_q <= 1'b0;
              r_sign_r <= 1'b0;
              r_dbz    <= 1'b1;
              r_state  <= DONE;
              busy     <= 1'b0;
            end
`endif
          end
        end
        BUSY: begin
          if (annul) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_rem <= w_next_rem;
            r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) begin
              r_state <= DONE;
              busy    <= 1'b0;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          if (!annul) begin
            done      <= 1'b1;
            quotient  <= r_sign_q ? WIDTH'(-r_dvd) : r_dvd;
            remainder <= r_sign_r ? WIDTH'(-r_rem) : r_rem;
`ifdef DIV_ZERO_CHECK_EN
            div_by_zero <= r_dbz;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
